// File: rtl/wb_user_pkg.sv
// Shared definitions for the user-area Wishbone slave arbiter:
// FSM state encoding, default address windows, error data and counter width.
package wb_user_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        B_WAIT = 2'd1,
        U_WAIT = 2'd2,
        ACK    = 2'd3
    } state_t;

    localparam logic [11:0] BRAM_BASE_DEF = 12'h380;
    localparam logic [11:0] UART_BASE_DEF = 12'h300;
    localparam logic [31:0] ERR_DATA      = 32'hDEAD_BEEF;
    localparam int          CNT_W         = 16;

    // Clamp an integer cycle count into the counter range so oversized or
    // negative parameters still produce a reachable terminal count.
    function automatic logic [CNT_W-1:0] sat_tc(input int v);
        if (v < 0) begin
            return '0;
        end else if (v > ((1 << CNT_W) - 1)) begin
            return '1;
        end else begin
            return CNT_W'(v);
        end
    endfunction

endpackage

// File: rtl/wb_wait_timer.sv
// Clear/enable cycle counter with a terminal-count compare. The counter
// saturates at all-ones so a stuck enable can never wrap back to a match.
module wb_wait_timer
    import wb_user_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_tc,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Count enabled cycles from zero, holding at the saturation value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == i_tc);

endmodule

// File: rtl/wb_user_slave_arbiter.sv
// Routes the single user-area Wishbone slave port to the user BRAM or the
// UART slave, inserts BRAM wait states, bounds UART cycles with a timeout and
// acks unmapped addresses so the management core can never hang.
module wb_user_slave_arbiter
    import wb_user_pkg::*;
#(
    parameter int          DELAYS    = 10,
    parameter int          TIMEOUT   = 255,
    parameter logic [11:0] BRAM_BASE = BRAM_BASE_DEF,
    parameter logic [11:0] UART_BASE = UART_BASE_DEF,
    parameter int          BRAM_AW   = 10
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic               bram_en,
    output logic [3:0]         bram_we,
    output logic [BRAM_AW-1:0] bram_addr,
    input  logic [31:0]        bram_rdata,
    output logic               uart_cyc_o,
    output logic               uart_stb_o,
    input  logic               uart_ack_i,
    input  logic [31:0]        uart_dat_i,
    output logic               timeout_o
);

    localparam logic [CNT_W-1:0] DELAY_TC   = sat_tc(DELAYS);
    localparam logic [CNT_W-1:0] TIMEOUT_TC = sat_tc(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_dat;
    logic [31:0]        w_dat_next;
    logic               r_timeout;
    logic               w_timeout_next;
    logic               w_clr;
    logic               w_en;
    logic               w_tc;
    logic [CNT_W-1:0]   w_tc_val;
    logic               w_req;
    logic               w_hit_bram;
    logic               w_hit_uart;
    logic               w_unused;

    assign w_req      = wbs_cyc_i & wbs_stb_i;
    assign w_hit_bram = (wbs_adr_i[31:20] == BRAM_BASE);
    assign w_hit_uart = (wbs_adr_i[31:20] == UART_BASE);

    // The same counter times BRAM wait states and the UART timeout; only the
    // compare value changes with the state.
    assign w_tc_val = (r_state == U_WAIT) ? TIMEOUT_TC : DELAY_TC;

    wb_wait_timer #(
        .W (CNT_W)
    ) u_timer (
        .i_clk (wb_clk_i),
        .i_rst (wb_rst_i),
        .i_clr (w_clr),
        .i_en  (w_en),
        .i_tc  (w_tc_val),
        .o_tc  (w_tc)
    );

    // State, response data and timeout pulse registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= IDLE;
            r_dat     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_dat     <= w_dat_next;
            r_timeout <= w_timeout_next;
        end
    end

    // Next-state decode; abort is checked before any completion so a dropped
    // cycle never produces an ack, and a UART ack wins over the timeout.
    always_comb begin
        w_next         = r_state;
        w_dat_next     = r_dat;
        w_timeout_next = 1'b0;
        w_clr          = 1'b0;
        w_en           = 1'b0;
        case (r_state)
            IDLE: begin
                w_clr = 1'b1;
                if (w_req) begin
                    if (w_hit_bram) begin
                        w_next = B_WAIT;
                    end else if (w_hit_uart) begin
                        w_next = U_WAIT;
                    end else begin
                        w_next     = ACK;
                        w_dat_next = '0;
                    end
                end
            end
            B_WAIT: begin
                w_en = 1'b1;
                if (!wbs_cyc_i) begin
                    w_next = IDLE;
                end else if (w_tc) begin
                    w_next     = ACK;
                    w_dat_next = bram_rdata;
                end
            end
            U_WAIT: begin
                w_en = 1'b1;
                if (!wbs_cyc_i) begin
                    w_next = IDLE;
                end else if (uart_ack_i) begin
                    w_next     = ACK;
                    w_dat_next = uart_dat_i;
                end else if (w_tc) begin
                    w_next         = ACK;
                    w_dat_next     = ERR_DATA;
                    w_timeout_next = 1'b1;
                end
            end
            ACK: begin
                w_clr  = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Strobes decode straight from the state register, so an asynchronous
    // reset drops every one of them immediately.
    assign wbs_ack_o  = (r_state == ACK);
    assign wbs_dat_o  = r_dat;
    assign timeout_o  = r_timeout;
    assign bram_en    = (r_state == B_WAIT);
    assign bram_we    = wbs_sel_i & {4{wbs_we_i}} & {4{r_state == B_WAIT}};
    assign bram_addr  = wbs_adr_i[BRAM_AW+1:2];
    assign uart_cyc_o = (r_state == U_WAIT);
    assign uart_stb_o = (r_state == U_WAIT);

    // Write data and the address bits outside the decode and word index reach
    // the targets over the shared bus, not through this block.
    assign w_unused = ^{wbs_dat_i, wbs_adr_i[19:BRAM_AW+2], wbs_adr_i[1:0]};

endmodule

// File: tb/tb_wb_user_slave_arbiter.sv
// Directed scoreboard bench for wb_user_slave_arbiter with a BRAM memory
// model and a UART responder with programmable ack delay.
module tb_wb_user_slave_arbiter;

    localparam int DELAYS  = 10;
    localparam int TIMEOUT = 255;
    localparam int BOUND   = 400;

    typedef struct {
        string       tag;
        logic [31:0] dat;
        bit          chk_dat;
        int          lat;
        bit          to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [9:0]  bram_addr;
    logic [31:0] bram_rdata;
    logic        uart_cyc, uart_stb;
    logic        uart_ack;
    logic [31:0] uart_dat;
    logic        timeout;

    logic [31:0] mem [0:1023];
    int          uart_ack_after = 0;
    logic [31:0] uart_resp = '0;
    int          ucnt = 0;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    wb_user_slave_arbiter #(
        .DELAYS  (DELAYS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_rdata (bram_rdata),
        .uart_cyc_o (uart_cyc),
        .uart_stb_o (uart_stb),
        .uart_ack_i (uart_ack),
        .uart_dat_i (uart_dat),
        .timeout_o  (timeout)
    );

    always #5 clk = ~clk;

    // BRAM model: byte-lane writes on the clock, combinational read.
    always @(posedge clk) begin
        if (bram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bram_we[b]) mem[bram_addr][8*b +: 8] <= wdat[8*b +: 8];
            end
        end
    end
    assign bram_rdata = mem[bram_addr];

    // UART model: ack for one cycle after uart_ack_after strobed cycles.
    always @(negedge clk) begin
        uart_ack = 1'b0;
        uart_dat = '0;
        if (uart_cyc && uart_stb) begin
            ucnt = ucnt + 1;
            if (uart_ack_after != 0 && ucnt == uart_ack_after) begin
                uart_ack = 1'b1;
                uart_dat = uart_resp;
            end
        end else begin
            ucnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Issue one request at a falling edge, wait for ack, pop and compare.
    task automatic access(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic w, input logic [3:0] s, input logic [31:0] exp_dat,
                          input bit chk_dat, input int exp_lat, input bit exp_to,
                          output bit seen_b, output bit seen_u);
        exp_t e;
        int   n;
        bit   got;
        bit   early_to;
        e.tag = tag; e.dat = exp_dat; e.chk_dat = chk_dat; e.lat = exp_lat; e.to = exp_to;
        q.push_back(e);
        adr = a; wdat = d; we = w; sel = s; cyc = 1'b1; stb = 1'b1;
        n = 0; got = 0; early_to = 0; seen_b = 0; seen_u = 0;
        while (!got && n < BOUND) begin
            @(negedge clk);
            n++;
            if (bram_en) seen_b = 1;
            if (uart_stb) seen_u = 1;
            if (ack) got = 1;
            else if (timeout) early_to = 1;
            if (n == 1 && a[31:20] == 12'h380) begin
                chk({tag, "_bram_we"}, {28'd0, bram_we}, {28'd0, s & {4{w}}});
                chk({tag, "_bram_addr"}, {22'd0, bram_addr}, {22'd0, a[11:2]});
            end
        end
        chk({tag, "_ack_seen"}, {31'd0, got}, 32'd1);
        e = q.pop_front();
        chk({e.tag, "_latency"}, n, e.lat);
        if (e.chk_dat) chk({e.tag, "_dat"}, rdat, e.dat);
        chk({e.tag, "_timeout"}, {31'd0, timeout}, {31'd0, e.to});
        chk({e.tag, "_early_timeout"}, {31'd0, early_to}, 32'd0);
        chk({e.tag, "_uart_stb_at_ack"}, {31'd0, uart_stb}, 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        chk({e.tag, "_ack_single"}, {31'd0, ack}, 32'd0);
        chk({e.tag, "_bram_en_after"}, {31'd0, bram_en}, 32'd0);
        chk({e.tag, "_timeout_single"}, {31'd0, timeout}, 32'd0);
    endtask

    initial begin
        bit          sb, su;
        bit          abort_ack;
        logic [31:0] held;

        rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = '0; adr = '0; wdat = '0;
        repeat (2) @(negedge clk);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", rdat, 32'd0);
        chk("rst_bram_en", {31'd0, bram_en}, 32'd0);
        chk("rst_bram_we", {28'd0, bram_we}, 32'd0);
        chk("rst_uart_cyc", {31'd0, uart_cyc}, 32'd0);
        chk("rst_uart_stb", {31'd0, uart_stb}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: BRAM write
        access("bram_wr", 32'h3800_0004, 32'hA5A5_5A5A, 1'b1, 4'hF, 32'd0, 0, DELAYS + 2, 0, sb, su);
        // 2: BRAM read back
        access("bram_rd", 32'h3800_0004, 32'd0, 1'b0, 4'hF, 32'hA5A5_5A5A, 1, DELAYS + 2, 0, sb, su);
        // 3: UART read acked after 3 cycles
        uart_ack_after = 3; uart_resp = 32'h0000_0041;
        access("uart_rd", 32'h3000_0000, 32'd0, 1'b0, 4'hF, 32'h0000_0041, 1, 4, 0, sb, su);
        // 4: UART never acks
        uart_ack_after = 0;
        access("uart_to", 32'h3000_0000, 32'd0, 1'b0, 4'hF, 32'hDEAD_BEEF, 1, TIMEOUT + 1, 1, sb, su);
        // 5: unmapped read
        access("unmapped", 32'h2600_0000, 32'd0, 1'b0, 4'hF, 32'd0, 1, 1, 0, sb, su);
        chk("unmapped_no_bram_en", {31'd0, sb}, 32'd0);
        chk("unmapped_no_uart_stb", {31'd0, su}, 32'd0);

        // 6a: abort a BRAM read at cycle 4
        access("uart_to2", 32'h3000_0000, 32'd0, 1'b0, 4'hF, 32'hDEAD_BEEF, 1, TIMEOUT + 1, 1, sb, su);
        held = rdat;
        adr = 32'h3800_0004; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        abort_ack = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack) abort_ack = 1;
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("abort_bram_en", {31'd0, bram_en}, 32'd0);
        repeat (15) begin
            if (ack) abort_ack = 1;
            @(negedge clk);
        end
        chk("abort_no_ack", {31'd0, abort_ack}, 32'd0);
        chk("abort_dat_held", rdat, held);

        // 6b: reset mid U_WAIT
        uart_ack_after = 0;
        adr = 32'h3000_0010; cyc = 1'b1; stb = 1'b1;
        repeat (5) @(negedge clk);
        chk("uwait_uart_stb", {31'd0, uart_stb}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_uart_stb", {31'd0, uart_stb}, 32'd0);
        chk("arst_uart_cyc", {31'd0, uart_cyc}, 32'd0);
        chk("arst_ack", {31'd0, ack}, 32'd0);
        chk("arst_timeout", {31'd0, timeout}, 32'd0);
        chk("arst_bram_en", {31'd0, bram_en}, 32'd0);
        chk("arst_dat", rdat, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 6c: BRAM access after reset
        access("bram_post_rst", 32'h3800_0004, 32'd0, 1'b0, 4'hF, 32'hA5A5_5A5A, 1, DELAYS + 2, 0, sb, su);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
